// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV64 core, with a mem_ready watchdog and sticky traps.
// Optional performance counters are compiled in with the CU_PERF_CNT_EN macro; without it the counter ports read 0.
module multi_cycle_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [6:0]       opcode_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             ir_write_o,
   output logic             iord_o,
   output logic             branch_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             mem_to_reg_o,
   output logic [1:0]       alu_op_o,
   output logic             alu_src_o,
   output logic             reg_write_o,
   output logic             illegal_instr_o,
   output logic             bus_error_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired_count_o,
   output logic [CNT_W-1:0] cycle_count_o
);

   // state  | meaning
   // FETCH  | read instruction at PC, load IR and bump PC on mem_ready
   // DECODE | latch opcode, reject undefined opcodes
   // EXEC   | ALU operation; branches resolve and retire here
   // MEM    | data access at ALU address; stores retire here
   // WB     | register file write; loads, R-type and I-type retire here
   // TRAP   | sticky error state, left only through reset

   localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit          WDOG_EN = (MEM_TIMEOUT != 0);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_e;

   state_e            state_q, state_d;
   logic [6:0]        opcode_q, opcode_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;
   logic              waiting;

   logic              pc_write_c, ir_write_c, iord_c, branch_c;
   logic              mem_read_c, mem_write_c, mem_to_reg_c;
   logic [1:0]        alu_op_c;
   logic              alu_src_c, reg_write_c;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_ITYPE: is_legal = 1'b1;
         default:                                          is_legal = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_FETCH;
         opcode_q  <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      wait_d    = '0;
      waiting   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready_i) state_d = ST_DECODE;
            else             waiting = 1'b1;
         end
         ST_DECODE: begin
            opcode_d = opcode_i;
            if (is_legal(opcode_i)) begin
               state_d = ST_EXEC;
            end else begin
               state_d   = ST_TRAP;
               illegal_d = 1'b1;
            end
         end
         ST_EXEC: begin
            case (opcode_q)
               OP_LOAD, OP_STORE:  state_d = ST_MEM;
               OP_BRANCH:          state_d = ST_FETCH;
               OP_RTYPE, OP_ITYPE: state_d = ST_WB;
               default: begin
                  state_d   = ST_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_MEM: begin
            if (mem_ready_i) state_d = (opcode_q == OP_LOAD) ? ST_WB : ST_FETCH;
            else             waiting = 1'b1;
         end
         ST_WB:   state_d = ST_FETCH;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_TRAP;
      endcase
      // mem_ready on the limit cycle never reaches here, so it always wins over the timeout
      if (waiting) begin
         if (WDOG_EN && (wait_q == WAIT_LIMIT)) begin
            state_d   = ST_TRAP;
            bus_err_d = 1'b1;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
   end

   always_comb begin
      pc_write_c   = 1'b0;
      ir_write_c   = 1'b0;
      iord_c       = 1'b0;
      branch_c     = 1'b0;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      mem_to_reg_c = 1'b0;
      alu_op_c     = 2'b00;
      alu_src_c    = 1'b0;
      reg_write_c  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_read_c = 1'b1;
            pc_write_c = mem_ready_i;
            ir_write_c = mem_ready_i;
         end
         ST_EXEC: begin
            case (opcode_q)
               OP_LOAD, OP_STORE: alu_src_c = 1'b1;
               OP_BRANCH: begin
                  alu_op_c = 2'b01;
                  branch_c = 1'b1;
               end
               OP_RTYPE: alu_op_c = 2'b10;
               OP_ITYPE: begin
                  alu_op_c  = 2'b11;
                  alu_src_c = 1'b1;
               end
               default: alu_op_c = 2'b00;
            endcase
         end
         ST_MEM: begin
            iord_c      = 1'b1;
            alu_src_c   = 1'b1;
            mem_read_c  = (opcode_q == OP_LOAD);
            mem_write_c = (opcode_q == OP_STORE);
         end
         ST_WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = (opcode_q == OP_LOAD);
         end
         default: reg_write_c = 1'b0;
      endcase
   end

   // Reset is synchronous, so outputs are gated directly to stay quiet while rst_n_i is low
   assign pc_write_o      = rst_n_i & pc_write_c;
   assign ir_write_o      = rst_n_i & ir_write_c;
   assign iord_o          = rst_n_i & iord_c;
   assign branch_o        = rst_n_i & branch_c;
   assign mem_read_o      = rst_n_i & mem_read_c;
   assign mem_write_o     = rst_n_i & mem_write_c;
   assign mem_to_reg_o    = rst_n_i & mem_to_reg_c;
   assign alu_op_o        = rst_n_i ? alu_op_c : 2'b00;
   assign alu_src_o       = rst_n_i & alu_src_c;
   assign reg_write_o     = rst_n_i & reg_write_c;
   assign illegal_instr_o = rst_n_i & illegal_q;
   assign bus_error_o     = rst_n_i & bus_err_q;
   assign state_o         = state_q;

`ifdef CU_PERF_CNT_EN
   logic [CNT_W-1:0] retired_q, cycle_q;
   logic             retire;

   assign retire = (state_d == ST_FETCH) &&
                   ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         retired_q <= '0;
         cycle_q   <= '0;
      end else begin
         cycle_q <= cycle_q + 1'b1;
         if (retire) retired_q <= retired_q + 1'b1;
      end
   end

   assign retired_count_o = retired_q;
   assign cycle_count_o   = cycle_q;
`else
   assign retired_count_o = '0;
   assign cycle_count_o   = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: the driver queues per-cycle expected outputs, the monitor compares them.
module tb_multi_cycle_control_unit;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [6:0]       opcode = '0;
   logic             mem_ready = 1'b0;
   logic             pc_write, ir_write, iord, branch, mem_read, mem_write, mem_to_reg;
   logic [1:0]       alu_op;
   logic             alu_src, reg_write, illegal_instr, bus_error;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired_count, cycle_count;

   always #5 clk = ~clk;

   multi_cycle_control_unit #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .opcode_i        (opcode),
      .mem_ready_i     (mem_ready),
      .pc_write_o      (pc_write),
      .ir_write_o      (ir_write),
      .iord_o          (iord),
      .branch_o        (branch),
      .mem_read_o      (mem_read),
      .mem_write_o     (mem_write),
      .mem_to_reg_o    (mem_to_reg),
      .alu_op_o        (alu_op),
      .alu_src_o       (alu_src),
      .reg_write_o     (reg_write),
      .illegal_instr_o (illegal_instr),
      .bus_error_o     (bus_error),
      .state_o         (state),
      .retired_count_o (retired_count),
      .cycle_count_o   (cycle_count)
   );

   typedef struct {
      string       name;
      logic [15:0] vec;
      logic [3:0]  ret;
      logic [3:0]  cyc;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       exp_ill = 1'b0;
   logic       exp_be  = 1'b0;
   logic [3:0] exp_ret = '0;
   logic [3:0] exp_cyc = '0;

   // vec = {state, pc_write, ir_write, iord, branch, mem_read, mem_write, mem_to_reg, alu_op, alu_src, reg_write, illegal, bus_error}
   function automatic logic [15:0] mk(input logic [2:0] st, input logic pcw, input logic irw, input logic io,
                                      input logic br, input logic mr, input logic mw, input logic m2r,
                                      input logic [1:0] aop, input logic asrc, input logic rw);
      return {st, pcw, irw, io, br, mr, mw, m2r, aop, asrc, rw, exp_ill, exp_be};
   endfunction

   function automatic logic [15:0] v_fetch(input logic rdy);
      return mk(3'd0, rdy, rdy, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
   endfunction

   function automatic logic [15:0] v_idle(input logic [2:0] st);
      return mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
   endfunction

   function automatic logic [15:0] v_exec(input logic [6:0] op);
      case (op)
         OP_BRANCH: return mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
         OP_RTYPE:  return mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
         OP_ITYPE:  return mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
         default:   return mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      endcase
   endfunction

   function automatic logic [15:0] v_mem(input logic [6:0] op);
      return mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, op == OP_LOAD, op == OP_STORE, 1'b0, 2'b00, 1'b1, 1'b0);
   endfunction

   function automatic logic [15:0] v_wb(input logic [6:0] op);
      return mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op == OP_LOAD, 2'b00, 1'b0, 1'b1);
   endfunction

   // Called at posedge+1: drive one cycle, queue its expectation, advance the counter model
   task automatic step(input string nm, input logic [6:0] op, input logic rdy, input logic rstn,
                       input logic [15:0] ev, input bit chk, input bit retire);
      exp_t e;
      opcode    = op;
      mem_ready = rdy;
      rst_n     = rstn;
      if (chk) begin
         e.name = nm;
         e.vec  = ev;
`ifdef CU_PERF_CNT_EN
         e.ret  = exp_ret;
         e.cyc  = exp_cyc;
`else
         e.ret  = 4'd0;
         e.cyc  = 4'd0;
`endif
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
         exp_ret = '0;
         exp_cyc = '0;
      end else begin
         exp_cyc = exp_cyc + 4'd1;
         if (retire) exp_ret = exp_ret + 4'd1;
      end
   endtask

   task automatic do_reset();
      step("reset_enter", 7'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
      exp_ill = 1'b0;
      exp_be  = 1'b0;
      step("reset_state", 7'd0, 1'b1, 1'b0, v_idle(3'd0), 1'b1, 1'b0);
   endtask

   task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait);
      for (int i = 0; i < fwait; i++)
         step($sformatf("fetch_wait%0d_%b", i, op), opcode, 1'b0, 1'b1, v_fetch(1'b0), 1'b1, 1'b0);
      step($sformatf("fetch_%b", op), opcode, 1'b1, 1'b1, v_fetch(1'b1), 1'b1, 1'b0);
      step($sformatf("decode_%b", op), op, 1'b0, 1'b1, v_idle(3'd1), 1'b1, 1'b0);
      step($sformatf("exec_%b", op), op, 1'b0, 1'b1, v_exec(op), 1'b1, op == OP_BRANCH);
      if (op == OP_LOAD || op == OP_STORE) begin
         for (int i = 0; i < mwait; i++)
            step($sformatf("mem_wait%0d_%b", i, op), op, 1'b0, 1'b1, v_mem(op), 1'b1, 1'b0);
         step($sformatf("mem_%b", op), op, 1'b1, 1'b1, v_mem(op), 1'b1, op == OP_STORE);
      end
      if (op == OP_LOAD || op == OP_RTYPE || op == OP_ITYPE)
         step($sformatf("wb_%b", op), op, 1'b0, 1'b1, v_wb(op), 1'b1, 1'b1);
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] act;
      if (sb_q.size() != 0) begin
         e   = sb_q.pop_front();
         act = {state, pc_write, ir_write, iord, branch, mem_read, mem_write, mem_to_reg,
                alu_op, alu_src, reg_write, illegal_instr, bus_error};
         checks++;
         if (act !== e.vec) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", e.name, act, e.vec);
         end
         checks++;
         if ({retired_count, cycle_count} !== {e.ret, e.cyc}) begin
            errors++;
            $display("FAIL %s_cnt: retired/cycle got %0d/%0d expected %0d/%0d",
                     e.name, retired_count, cycle_count, e.ret, e.cyc);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      opcode    = '0;
      @(posedge clk);
      #1;
      do_reset();

      run_instr(OP_RTYPE, 0, 0);
      run_instr(OP_LOAD, 0, 3);
      run_instr(OP_STORE, 0, 0);
      run_instr(OP_BRANCH, 0, 0);
      run_instr(OP_ITYPE, 2, 0);
      // ready arriving exactly on the limit cycle, in FETCH and in MEM
      run_instr(OP_LOAD, MEM_TIMEOUT, MEM_TIMEOUT);

      step("ill_fetch", opcode, 1'b1, 1'b1, v_fetch(1'b1), 1'b1, 1'b0);
      step("ill_decode", OP_BAD, 1'b0, 1'b1, v_idle(3'd1), 1'b1, 1'b0);
      exp_ill = 1'b1;
      for (int i = 0; i < 12; i++)
         step($sformatf("ill_trap%0d", i), OP_RTYPE, i[0], 1'b1, v_idle(3'd7), 1'b1, 1'b0);
      do_reset();
      run_instr(OP_RTYPE, 0, 0);

      for (int i = 0; i <= MEM_TIMEOUT; i++)
         step($sformatf("wd_fetch%0d", i), opcode, 1'b0, 1'b1, v_fetch(1'b0), 1'b1, 1'b0);
      exp_be = 1'b1;
      for (int i = 0; i < 4; i++)
         step($sformatf("wd_trap%0d", i), opcode, 1'b1, 1'b1, v_idle(3'd7), 1'b1, 1'b0);
      do_reset();

      step("wdm_fetch", opcode, 1'b1, 1'b1, v_fetch(1'b1), 1'b1, 1'b0);
      step("wdm_decode", OP_STORE, 1'b0, 1'b1, v_idle(3'd1), 1'b1, 1'b0);
      step("wdm_exec", OP_STORE, 1'b0, 1'b1, v_exec(OP_STORE), 1'b1, 1'b0);
      for (int i = 0; i <= MEM_TIMEOUT; i++)
         step($sformatf("wdm_mem%0d", i), OP_STORE, 1'b0, 1'b1, v_mem(OP_STORE), 1'b1, 1'b0);
      exp_be = 1'b1;
      step("wdm_trap0", OP_STORE, 1'b1, 1'b1, v_idle(3'd7), 1'b1, 1'b0);
      step("wdm_trap1", OP_STORE, 1'b0, 1'b1, v_idle(3'd7), 1'b1, 1'b0);
      do_reset();

      step("rmem_fetch", opcode, 1'b1, 1'b1, v_fetch(1'b1), 1'b1, 1'b0);
      step("rmem_decode", OP_LOAD, 1'b0, 1'b1, v_idle(3'd1), 1'b1, 1'b0);
      step("rmem_exec", OP_LOAD, 1'b0, 1'b1, v_exec(OP_LOAD), 1'b1, 1'b0);
      step("rmem_mem", OP_LOAD, 1'b0, 1'b1, v_mem(OP_LOAD), 1'b1, 1'b0);
      do_reset();

      for (int i = 0; i < 20; i++)
         run_instr(OP_RTYPE, 0, 0);
      step("perf_after", opcode, 1'b0, 1'b1, v_fetch(1'b0), 1'b1, 1'b0);

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
